// File: rtl/reg_to_apb_pkg.sv
// -----------------------------------------------------------------------------
// reg_to_apb_pkg
//   Shared types and sizing helpers for the register-to-APB initiator bridge.
//   - state_e      : bridge FSM states (IDLE/SETUP/ACCESS/RESP)
//   - clog2_min1() : index width for a select vector, never below 1 bit
//   - to_width()   : width of a counter that must hold 0..TIMEOUT_CYCLES
//   - IDX_W / TO_W : widths for the default configuration (4 slaves, 255 cycles)
// -----------------------------------------------------------------------------
package reg_to_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam int DEF_NUM_SLAVES     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  // A single-slave bridge still needs a 1-bit index so slicing stays legal.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int to_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

  localparam int IDX_W = clog2_min1(DEF_NUM_SLAVES);
  localparam int TO_W  = to_width(DEF_TIMEOUT_CYCLES);

endpackage : reg_to_apb_pkg

// File: rtl/reg_to_apb_decode.sv
// -----------------------------------------------------------------------------
// reg_to_apb_decode
//   Combinational address decoder: maps a byte address onto one of NUM_SLAVES
//   equally sized regions starting at BASE_ADDR.
//   Ports:
//     addr_i  in  ADDR_WIDTH  byte address to decode
//     hit_o   out 1           address falls inside one of the slave regions
//     idx_o   out IDX_W       region index, meaningful only when hit_o=1
// -----------------------------------------------------------------------------
module reg_to_apb_decode
  import reg_to_apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    NUM_SLAVES    = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = ADDR_WIDTH'(32'h1A10_0000),
  parameter int                    SLV_SIZE_LOG2 = 12,
  parameter int                    IDX_W         = clog2_min1(NUM_SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  hit_o,
  output logic [IDX_W-1:0]      idx_o
);

  logic [ADDR_WIDTH-1:0] w_offset;
  logic [ADDR_WIDTH-1:0] w_region;

  // Below-base addresses wrap to a huge offset; the explicit >= check rejects
  // them even when the wrapped region number happens to look small.
  assign w_offset = addr_i - BASE_ADDR;
  assign w_region = w_offset >> SLV_SIZE_LOG2;
  assign hit_o    = (addr_i >= BASE_ADDR) && (w_region < ADDR_WIDTH'(NUM_SLAVES));
  assign idx_o    = w_region[IDX_W-1:0];

endmodule : reg_to_apb_decode

// File: rtl/reg_to_apb_bridge.sv
// -----------------------------------------------------------------------------
// reg_to_apb_bridge
//   Turns single REG_BUS-style requests into APB4 SETUP/ACCESS transfers on one
//   of NUM_SLAVES decoded slaves, and returns rdata/error to the requester.
//   A wait-state timeout forces an error response if a slave never answers.
//   Ports:
//     clk_i, rst_i            clock, asynchronous active-high reset
//     reg_addr_i/_write_i/_wdata_i/_wstrb_i/_valid_i   request (held until ready)
//     reg_ready_o/_rdata_o/_error_o                    one-cycle response
//     paddr_o/pwrite_o/pwdata_o/pstrb_o/psel_o/penable_o  APB4 initiator outputs
//     prdata_i/pready_i/pslverr_i                      per-slave APB returns
// -----------------------------------------------------------------------------
module reg_to_apb_bridge
  import reg_to_apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    NUM_SLAVES     = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = ADDR_WIDTH'(32'h1A10_0000),
  parameter int                    SLV_SIZE_LOG2  = 12,
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [ADDR_WIDTH-1:0]            reg_addr_i,
  input  logic                             reg_write_i,
  input  logic [DATA_WIDTH-1:0]            reg_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]          reg_wstrb_i,
  input  logic                             reg_valid_i,
  output logic                             reg_ready_o,
  output logic [DATA_WIDTH-1:0]            reg_rdata_o,
  output logic                             reg_error_o,
  output logic [ADDR_WIDTH-1:0]            paddr_o,
  output logic                             pwrite_o,
  output logic [DATA_WIDTH-1:0]            pwdata_o,
  output logic [DATA_WIDTH/8-1:0]          pstrb_o,
  output logic [NUM_SLAVES-1:0]            psel_o,
  output logic                             penable_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata_i,
  input  logic [NUM_SLAVES-1:0]            pready_i,
  input  logic [NUM_SLAVES-1:0]            pslverr_i
);

  localparam int SEL_W  = clog2_min1(NUM_SLAVES);
  localparam int CNT_W  = to_width(TIMEOUT_CYCLES);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                  r_state;
  logic [SEL_W-1:0]        r_idx;
  logic [CNT_W-1:0]        r_cnt;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic                    r_pwrite;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic [STRB_W-1:0]       r_pstrb;
  logic [NUM_SLAVES-1:0]   r_psel;
  logic                    r_penable;
  logic                    r_ready;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_error;

  logic                    w_hit;
  logic [SEL_W-1:0]        w_idx;
  logic                    w_sel_ready;
  logic                    w_sel_err;
  logic [DATA_WIDTH-1:0]   w_sel_rdata;
  logic [NUM_SLAVES-1:0]   w_sel_onehot;

  reg_to_apb_decode #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .NUM_SLAVES    (NUM_SLAVES),
    .BASE_ADDR     (BASE_ADDR),
    .SLV_SIZE_LOG2 (SLV_SIZE_LOG2),
    .IDX_W         (SEL_W)
  ) u_decode (
    .addr_i (reg_addr_i),
    .hit_o  (w_hit),
    .idx_o  (w_idx)
  );

  assign w_sel_onehot = NUM_SLAVES'(1) << w_idx;

  // Only the selected slave's return signals are ever looked at; stray
  // pready/pslverr from other slaves cannot complete or fail a transfer.
  assign w_sel_ready = pready_i[r_idx];
  assign w_sel_err   = pslverr_i[r_idx];
  assign w_sel_rdata = prdata_i[r_idx*DATA_WIDTH +: DATA_WIDTH];

  // NOTE: every state register here uses non-blocking assignment so all of
  // them update from the same pre-edge values; blocking would let later lines
  // see already-updated state and break the cycle-exact APB phases.
  // NOTE: the data registers (address, write data, read data) are reset too,
  // because every output drives straight from a register and must read 0
  // while idle or in reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_ready   <= 1'b0;
      r_rdata   <= '0;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (reg_valid_i) begin
            if (w_hit) begin
              r_paddr  <= reg_addr_i;
              r_pwrite <= reg_write_i;
              r_pwdata <= reg_wdata_i;
              r_pstrb  <= reg_write_i ? reg_wstrb_i : '0;
              r_psel   <= w_sel_onehot;
              r_idx    <= w_idx;
              r_state  <= ST_SETUP;
            end else begin
              // Decode miss: answer immediately, never touch the APB side.
              r_ready  <= 1'b1;
              r_error  <= 1'b1;
              r_rdata  <= '0;
              r_state  <= ST_RESP;
            end
          end
        end

        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          // Completion is tested first so a pready on the expiry cycle wins.
          if (w_sel_ready || (r_cnt == CNT_LAST)) begin
            r_ready   <= 1'b1;
            r_error   <= w_sel_ready ? w_sel_err : 1'b1;
            r_rdata   <= (w_sel_ready && !r_pwrite) ? w_sel_rdata : '0;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_state   <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        ST_RESP: begin
          r_ready <= 1'b0;
          r_error <= 1'b0;
          r_rdata <= '0;
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign reg_ready_o = r_ready;
  assign reg_rdata_o = r_rdata;
  assign reg_error_o = r_error;
  assign paddr_o     = r_paddr;
  assign pwrite_o    = r_pwrite;
  assign pwdata_o    = r_pwdata;
  assign pstrb_o     = r_pstrb;
  assign psel_o      = r_psel;
  assign penable_o   = r_penable;

endmodule : reg_to_apb_bridge

// File: tb/tb_reg_to_apb_bridge.sv
// -----------------------------------------------------------------------------
// tb_reg_to_apb_bridge
//   Scoreboard bench for reg_to_apb_bridge (4 slaves, TIMEOUT_CYCLES=8).
//   Stimulus issues requests and pushes the predicted response; a separate
//   monitor checks every APB cycle and every reg_ready_o against the queue.
// -----------------------------------------------------------------------------
module tb_reg_to_apb_bridge;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          NS   = 4;
  localparam logic [31:0] BASE = 32'h1A10_0000;
  localparam int          SZL2 = 12;
  localparam int          TO   = 8;

  logic              clk;
  logic              rst_i;
  logic [AW-1:0]     reg_addr_i;
  logic              reg_write_i;
  logic [DW-1:0]     reg_wdata_i;
  logic [DW/8-1:0]   reg_wstrb_i;
  logic              reg_valid_i;
  logic              reg_ready_o;
  logic [DW-1:0]     reg_rdata_o;
  logic              reg_error_o;
  logic [AW-1:0]     paddr_o;
  logic              pwrite_o;
  logic [DW-1:0]     pwdata_o;
  logic [DW/8-1:0]   pstrb_o;
  logic [NS-1:0]     psel_o;
  logic              penable_o;
  logic [NS*DW-1:0]  prdata_i;
  logic [NS-1:0]     pready_i;
  logic [NS-1:0]     pslverr_i;

  reg_to_apb_bridge #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .NUM_SLAVES     (NS),
    .BASE_ADDR      (BASE),
    .SLV_SIZE_LOG2  (SZL2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .reg_addr_i  (reg_addr_i),
    .reg_write_i (reg_write_i),
    .reg_wdata_i (reg_wdata_i),
    .reg_wstrb_i (reg_wstrb_i),
    .reg_valid_i (reg_valid_i),
    .reg_ready_o (reg_ready_o),
    .reg_rdata_o (reg_rdata_o),
    .reg_error_o (reg_error_o),
    .paddr_o     (paddr_o),
    .pwrite_o    (pwrite_o),
    .pwdata_o    (pwdata_o),
    .pstrb_o     (pstrb_o),
    .psel_o      (psel_o),
    .penable_o   (penable_o),
    .prdata_i    (prdata_i),
    .pready_i    (pready_i),
    .pslverr_i   (pslverr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: expected outcome of one request, from the decode window,
  // the slave's behaviour and the latency/timeout rules.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    bit          write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    bit          hit;
    int          idx;
    int          acc;      // cycles with penable high
    logic [31:0] rdata;
    bit          err;
    int          cyc;      // cycle count at which reg_ready_o is seen
  } exp_t;

  exp_t sb[$];

  // Slave behaviour for the transfer in flight: ACCESS cycles before pready
  // (-1 = never), pslverr value, and read data presented.
  int          cfg_waits = 0;
  bit          cfg_err   = 1'b0;
  logic [31:0] cfg_rdata = '0;

  function automatic exp_t model(input logic [31:0] addr, input bit write,
                                 input logic [31:0] wdata, input logic [3:0] strb,
                                 input int waits, input bit err,
                                 input logic [31:0] rdata, input int now);
    exp_t   e;
    longint off;
    bit     timed_out;
    int     lat;
    off       = longint'(addr) - longint'(BASE);
    e.addr    = addr;
    e.write   = write;
    e.wdata   = wdata;
    e.strb    = strb;
    e.hit     = (off >= 0) && ((off / 4096) < NS);
    e.idx     = e.hit ? int'(off / 4096) : 0;
    timed_out = e.hit && ((waits < 0) || (waits >= TO));
    e.acc     = !e.hit ? 0 : (timed_out ? TO : waits + 1);
    lat       = !e.hit ? 2 : e.acc + 3;
    e.err     = !e.hit || timed_out || err;
    e.rdata   = (e.hit && !timed_out && !write) ? rdata : 32'h0;
    e.cyc     = now + lat - 1;
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // APB slave model: drives the selected slave from cfg_*, random noise on the
  // others.
  // ---------------------------------------------------------------------------
  int acc_cnt = 0;

  always @(negedge clk) begin
    bit ready_now;
    ready_now = 1'b0;
    if (!rst_i && (psel_o != '0) && penable_o) begin
      ready_now = (acc_cnt == cfg_waits);
      acc_cnt++;
    end else begin
      acc_cnt = 0;
    end
    pready_i  = (NS'($urandom) & ~psel_o) | (ready_now ? psel_o : '0);
    pslverr_i = (NS'($urandom) & ~psel_o) | (cfg_err ? psel_o : '0);
    for (int k = 0; k < NS; k++)
      prdata_i[k*DW +: DW] = psel_o[k] ? cfg_rdata : DW'($urandom);
  end

  // ---------------------------------------------------------------------------
  // Monitor: APB phase/stability checks every cycle, response checks on ready.
  // ---------------------------------------------------------------------------
  int   mon_setup = 0;
  int   mon_en    = 0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst_i) begin
      mon_setup = 0;
      mon_en    = 0;
    end else begin
      if (psel_o != '0) begin
        if (sb.size() == 0) begin
          check("psel_without_request", 128'(psel_o), 128'(0));
        end else begin
          check("psel_onehot", 128'(psel_o), 128'(4'b0001 << sb[0].idx));
          check("apb_fields", {paddr_o, pwrite_o, pwdata_o, pstrb_o},
                {sb[0].addr, sb[0].write, sb[0].wdata, (sb[0].write ? sb[0].strb : 4'h0)});
          if (penable_o) mon_en++;
          else           mon_setup++;
        end
      end else begin
        check("apb_idle", {penable_o, paddr_o, pwrite_o, pwdata_o, pstrb_o}, 128'(0));
      end

      if (reg_ready_o) begin
        if (sb.size() == 0) begin
          check("ready_without_request", 128'(reg_ready_o), 128'(0));
        end else begin
          mon_e = sb.pop_front();
          check("resp_rdata",  128'(reg_rdata_o), 128'(mon_e.rdata));
          check("resp_error",  128'(reg_error_o), 128'(mon_e.err));
          check("resp_cycle",  128'(cyc),         128'(mon_e.cyc));
          check("setup_cycles", 128'(mon_setup),  128'(mon_e.hit ? 1 : 0));
          check("penable_cycles", 128'(mon_en),   128'(mon_e.acc));
        end
        mon_setup = 0;
        mon_en    = 0;
      end else begin
        check("resp_idle", {reg_rdata_o, reg_error_o}, 128'(0));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [31:0] addr, input bit write, input logic [31:0] wdata,
                       input logic [3:0] strb, input int waits, input bit err,
                       input logic [31:0] rdata);
    @(negedge clk);
    cfg_waits   = waits;
    cfg_err     = err;
    cfg_rdata   = rdata;
    reg_addr_i  = addr;
    reg_write_i = write;
    reg_wdata_i = wdata;
    reg_wstrb_i = strb;
    reg_valid_i = 1'b1;
    sb.push_back(model(addr, write, wdata, strb, waits, err, rdata, cyc));
  endtask

  task automatic wait_ready();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (reg_ready_o) begin
        got = 1'b1;
        break;
      end
      // Request fields are scrambled while in flight; the bridge must ignore them.
      reg_addr_i  = $urandom;
      reg_wdata_i = $urandom;
      reg_write_i = 1'($urandom);
      reg_wstrb_i = 4'($urandom);
    end
    reg_valid_i = 1'b0;
    if (!got) begin
      check("ready_timeout", 128'(reg_ready_o), 128'(1));
      #2 rst_i = 1'b1;
      sb.delete();
      @(negedge clk);
      #2 rst_i = 1'b0;
    end
  endtask

  task automatic xfer(input logic [31:0] addr, input bit write, input logic [31:0] wdata,
                      input logic [3:0] strb, input int waits, input bit err,
                      input logic [31:0] rdata);
    issue(addr, write, wdata, strb, waits, err, rdata);
    wait_ready();
  endtask

  initial begin
    bit got_en;
    rst_i       = 1'b1;
    reg_addr_i  = '0;
    reg_write_i = 1'b0;
    reg_wdata_i = '0;
    reg_wstrb_i = '0;
    reg_valid_i = 1'b0;
    pready_i    = '0;
    pslverr_i   = '0;
    prdata_i    = '0;

    repeat (3) @(negedge clk);
    check("reset_outputs",
          {psel_o, penable_o, reg_ready_o, reg_rdata_o, reg_error_o, paddr_o, pwrite_o, pstrb_o},
          128'(0));
    #2 rst_i = 1'b0;

    // Directed cases
    xfer(BASE + 32'h1004, 1'b1, 32'hCAFE_F00D, 4'hF, 0, 1'b0, 32'h0);        // write slave 1
    xfer(BASE + 32'h3010, 1'b0, 32'h0, 4'hA, 3, 1'b0, 32'h1234_5678);        // read slave 3, 3 waits
    xfer(BASE + 32'h2008, 1'b1, 32'h5555_AAAA, 4'h3, 1, 1'b1, 32'h0);        // slverr on slave 2
    xfer(BASE + 32'h0000, 1'b0, 32'h0, 4'h0, -1, 1'b0, 32'hDEAD_BEEF);       // timeout
    xfer(BASE + 32'h0004, 1'b0, 32'h0, 4'h0, TO - 1, 1'b0, 32'h0BAD_CAFE);   // pready on last cycle
    xfer(BASE + 32'h4000, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h1111_1111);        // miss above
    xfer(BASE - 32'h4,    1'b1, 32'h1, 4'hF, 0, 1'b0, 32'h0);                // miss below

    // Reset in the middle of ACCESS: outputs clear at once, no response
    issue(BASE + 32'h0010, 1'b0, 32'h0, 4'h0, -1, 1'b0, 32'h7777_7777);
    got_en = 1'b0;
    for (int i = 0; i < 10 && !got_en; i++) begin
      @(negedge clk);
      got_en = penable_o;
    end
    check("reached_access", 128'(penable_o), 128'(1));
    #2 rst_i = 1'b1;
    sb.delete();
    #1 check("async_reset_clear", {psel_o, penable_o, reg_ready_o}, 128'(0));
    reg_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_i = 1'b0;
    xfer(BASE + 32'h1FFC, 1'b0, 32'h0, 4'h0, 2, 1'b0, 32'hA5A5_5A5A);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      logic [31:0] addr;
      int          w;
      int          sel;
      sel = $urandom_range(0, 9);
      if (sel <= 6)      addr = BASE + $urandom_range(0, 5 * 4096 - 1);
      else if (sel == 7) addr = BASE - 4 * $urandom_range(1, 64);
      else if (sel == 8) addr = $urandom;
      else               addr = BASE + 32'h3FFC;
      w = $urandom_range(0, 12);
      if (w == 12) w = -1;
      xfer(addr, 1'($urandom), $urandom, 4'($urandom), w, 1'($urandom_range(0, 3) == 0), $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_reg_to_apb_bridge

// File: doc/reg_to_apb_bridge.md
Name: reg_to_apb_bridge

Overview:
- Initiator-side counterpart of the APB-to-register converters in the host APB subsystem.
- Accepts single REG_BUS-style requests from a register master, for example a debug or padframe-config initiator that must reach APB-only peripherals.
- Decodes the address to one of NUM_SLAVES APB slaves and runs a full APB4 SETUP/ACCESS transfer.
- Returns rdata/error to the requester, with a wait-state timeout so a hung slave cannot stall the register master.

Parameters:
- ADDR_WIDTH, 32, width of reg and APB address.
- DATA_WIDTH, 32, width of reg and APB data.
- NUM_SLAVES, 4, number of psel lines, >=1.
- BASE_ADDR, 32'h1A10_0000, start of decoded window.
- SLV_SIZE_LOG2, 12, log2 of bytes per slave region.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before forced error, >=1.

Ports:
- clk_i  in  1  single clock (all logic)
- rst_i  in  1  asynchronous, active-high reset
- reg_addr_i  in  ADDR_WIDTH  request byte address
- reg_write_i  in  1  1=write, 0=read
- reg_wdata_i  in  DATA_WIDTH  write data
- reg_wstrb_i  in  DATA_WIDTH/8  byte strobes
- reg_valid_i  in  1  request valid, held until reg_ready_o
- reg_ready_o  out  1  one-cycle response strobe
- reg_rdata_o  out  DATA_WIDTH  read data, valid when reg_ready_o=1
- reg_error_o  out  1  error flag, valid when reg_ready_o=1
- paddr_o  out  ADDR_WIDTH  APB address (full, unmodified)
- pwrite_o  out  1  APB direction
- pwdata_o  out  DATA_WIDTH  APB write data
- pstrb_o  out  DATA_WIDTH/8  APB4 strobes (forced 0 on reads)
- psel_o  out  NUM_SLAVES  one-hot slave select
- penable_o  out  1  APB enable
- prdata_i  in  NUM_SLAVES*DATA_WIDTH  per-slave read data, slave k at [k*DW +: DW]
- pready_i  in  NUM_SLAVES  per-slave ready
- pslverr_i  in  NUM_SLAVES  per-slave error

Behaviour:

Reset:
- rst_i=1 forces the FSM to IDLE immediately, asynchronously.
- All outputs go to 0, including psel_o and penable_o. The timeout counter goes to 0.
- Reset mid-transfer aborts the transfer. No reg_ready_o is issued for it.

FSM states: IDLE, SETUP, ACCESS, RESP.

IDLE:
- All outputs 0.
- On reg_valid_i=1, register addr/write/wdata/wstrb into the APB output registers and decode.
- Decode hit: idx = (addr-BASE_ADDR)>>SLV_SIZE_LOG2, valid when addr>=BASE_ADDR and idx<NUM_SLAVES. Go to SETUP.
- Decode miss: go to RESP with error=1 and rdata=0. No APB activity; psel_o stays 0.

SETUP (exactly 1 cycle):
- psel_o[idx]=1, penable_o=0. Go to ACCESS.

ACCESS:
- psel_o[idx]=1, penable_o=1. Only pready_i[idx], pslverr_i[idx] and prdata_i slice idx are observed.
- When pready_i[idx]=1:
  - capture rdata = prdata slice idx on reads, 0 on writes;
  - capture error = pslverr_i[idx];
  - go to RESP. psel_o and penable_o drop in the next cycle.
- Otherwise increment the counter.
- When the counter reaches TIMEOUT_CYCLES-1 with pready still 0, go to RESP with error=1 and rdata=0.
- pready=1 on the same cycle as expiry counts as normal completion; completion has priority.

APB output stability:
- paddr/pwrite/pwdata/pstrb are constant from SETUP through the last ACCESS cycle.
- They return to 0 in RESP and IDLE.

RESP (exactly 1 cycle):
- reg_ready_o=1, with reg_rdata_o and reg_error_o driven from registers.
- Counter cleared. Go to IDLE.
- The requester drops or changes valid after the ready cycle.
- A new request is sampled in the following IDLE cycle, so there is no back-to-back acceptance in RESP.

Latency, valid to ready:
- Zero-wait slave: 4 cycles (IDLE sample, SETUP, ACCESS, RESP).
- +1 cycle per wait state.
- Decode error: 2 cycles.

Other rules:
- reg_* inputs are ignored outside IDLE.
- Changes to reg_* inputs while a transfer is in flight have no effect.
- reg_ready_o, reg_rdata_o and reg_error_o are registered outputs.
- pprot is not provided; slaves tie it off.

Decomposition:
- Package reg_to_apb_pkg:
  - state enum typedef (IDLE/SETUP/ACCESS/RESP);
  - localparam IDX_W = $clog2(NUM_SLAVES) (min 1);
  - localparam TO_W = $clog2(TIMEOUT_CYCLES+1).
- Sub-module reg_to_apb_decode: combinational hit/idx computation from addr, BASE_ADDR, SLV_SIZE_LOG2 and NUM_SLAVES. Reusable for other bridges.
- FSM, counter and output registers stay in the top module.

Test Plan:
1. Write to BASE+0x1004 (slave 1), wdata 0xCAFEF00D, wstrb 0xF, slave 1 pready=1 in ACCESS:
   - psel_o=4'b0010 for 2 cycles, penable_o high only in the 2nd;
   - pstrb_o=0xF; reg_ready_o at cycle 4, error=0.
2. Read from BASE+0x3010 (slave 3), 3 wait states, prdata slice 3=0x12345678:
   - reg_ready_o at cycle 7;
   - rdata=0x12345678; pstrb_o=0 during transfer.
3. Write to slave 2 with pslverr_i[2]=1 on the pready cycle:
   - error=1 returned.
   - pslverr on non-selected slaves during other transfers is ignored.
4. TIMEOUT_CYCLES=8, slave 0 never asserts pready:
   - penable high for exactly 8 cycles;
   - reg_ready_o=1, error=1, rdata=0; psel_o=0 in the next cycle.
   - Repeat with pready asserted on the 8th cycle: error=0.
5. Decode miss, with addr=BASE+0x4000 (NUM_SLAVES=4) and with addr=BASE-4:
   - psel_o stays 0;
   - reg_ready_o after 2 cycles with error=1.
6. rst_i asserted mid-ACCESS:
   - psel_o, penable_o and reg_ready_o go to 0 asynchronously (same cycle);
   - after release, a new read completes normally.
